// File: rtl/sobel_window_ctrl.sv
// Sobel 3x3 window sequencer: tracks raster position, drives shift/line-buffer enables, flags complete windows.
// Latency: a window is valid one cycle after the accept of its bottom-right pixel.
// Backpressure: in_ready = !win_valid || win_ready (blocked in DRAIN); optional BORDER_OUT_EN adds border beats and flush.
module sobel_window_ctrl #(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540,
    parameter int COL_W      = 10,
    parameter int ROW_W      = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             shift_en,
    output logic             lb_wr_en,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [COL_W-1:0] win_col,
    output logic [ROW_W-1:0] win_row,
`ifdef BORDER_OUT_EN
    output logic             win_border,
`endif
    output logic             frame_done,
    output logic             busy
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             win_valid_q, win_valid_d;
    logic [COL_W-1:0] win_col_q, win_col_d;
    logic [ROW_W-1:0] win_row_q, win_row_d;

    logic             out_free, accept, flush, last_px, beat;
    logic [COL_W-1:0] beat_col;
    logic [ROW_W-1:0] beat_row;

`ifdef BORDER_OUT_EN
    localparam int FW = COL_W + 1;
    localparam logic [FW-1:0] FLUSH_N = FW'(IMG_WIDTH + 1);
    logic [FW-1:0]    flush_q, flush_d;
    logic [COL_W-1:0] ocol_q, ocol_d;
    logic [ROW_W-1:0] orow_q, orow_d;
    logic             win_border_q, win_border_d, beat_border;
`endif

    // Handshake, enables and the coordinates of the beat produced this cycle
    always_comb begin
        out_free = !win_valid_q || win_ready;
        in_ready = out_free && (state_q != S_DRAIN);
        accept   = in_valid && in_ready;
        last_px  = (col_q == COL_LAST) && (row_q == ROW_LAST);
        flush    = 1'b0;
`ifdef BORDER_OUT_EN
        // Centre trails input by one row plus one column; border centres are flagged so downstream writes zero
        flush       = (state_q == S_DRAIN) && (flush_q != '0) && out_free;
        beat        = (accept && ((row_q >= ROW_W'(2)) || ((row_q == ROW_W'(1)) && (col_q != '0)))) || flush;
        beat_col    = ocol_q;
        beat_row    = orow_q;
        beat_border = (orow_q == '0) || (orow_q == ROW_LAST) || (ocol_q == '0) || (ocol_q == COL_LAST);
`else
        beat     = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
        beat_col = col_q - COL_W'(1);
        beat_row = row_q - ROW_W'(1);
`endif
        shift_en = accept || flush;
        lb_wr_en = accept || flush;
    end

    // Raster position of the next input pixel; wraps at end of line and frame
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

`ifdef BORDER_OUT_EN
    // Output centre position, advanced once per produced beat
    always_comb begin
        ocol_d = ocol_q;
        orow_d = orow_q;
        if (beat) begin
            if (ocol_q == COL_LAST) begin
                ocol_d = '0;
                orow_d = (orow_q == ROW_LAST) ? '0 : orow_q + ROW_W'(1);
            end else begin
                ocol_d = ocol_q + COL_W'(1);
            end
        end
    end
`endif

    // Single output stage: load on a new beat, otherwise clear once consumed
    always_comb begin
        win_valid_d = win_valid_q;
        win_col_d   = win_col_q;
        win_row_d   = win_row_q;
`ifdef BORDER_OUT_EN
        win_border_d = win_border_q;
`endif
        if (beat) begin
            win_valid_d = 1'b1;
            win_col_d   = beat_col;
            win_row_d   = beat_row;
`ifdef BORDER_OUT_EN
            win_border_d = beat_border;
`endif
        end else if (win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    // Frame sequencing FSM: next state and status outputs
    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        busy       = (state_q != S_IDLE);
`ifdef BORDER_OUT_EN
        flush_d = flush ? flush_q - FW'(1) : flush_q;
`endif
        case (state_q)
            S_IDLE:  if (accept) state_d = S_FILL;
            S_FILL:  if (accept && (col_q == COL_LAST) && (row_q == ROW_W'(1))) state_d = S_RUN;
            S_RUN: begin
                if (accept && last_px) begin
                    state_d = S_DRAIN;
`ifdef BORDER_OUT_EN
                    flush_d = FLUSH_N;
`endif
                end
            end
            S_DRAIN: begin
`ifdef BORDER_OUT_EN
                if (win_valid_q && win_ready && (flush_q == '0)) state_d = S_DONE;
`else
                if (win_valid_q && win_ready) state_d = S_DONE;
`endif
            end
            S_DONE: begin
                frame_done = 1'b1;
                // A pixel offered during DONE already belongs to the next frame
                state_d    = accept ? S_FILL : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset that discards any partial frame
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            win_col_q   <= '0;
            win_row_q   <= '0;
`ifdef BORDER_OUT_EN
            flush_q      <= '0;
            ocol_q       <= '0;
            orow_q       <= '0;
            win_border_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
            win_col_q   <= win_col_d;
            win_row_q   <= win_row_d;
`ifdef BORDER_OUT_EN
            flush_q      <= flush_d;
            ocol_q       <= ocol_d;
            orow_q       <= orow_d;
            win_border_q <= win_border_d;
`endif
        end
    end

    assign win_valid = win_valid_q;
    assign win_col   = win_col_q;
    assign win_row   = win_row_q;
`ifdef BORDER_OUT_EN
    assign win_border = win_border_q;
`endif

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl on a 5x4 image.
// Covers reset state, streaming, output stall, input gap, mid-frame reset and back-to-back frames.
// Inputs change #1 after the rising edge; outputs are observed on the falling edge.
module tb_sobel_window_ctrl;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int CW = 3;
    localparam int RW = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          win_ready = 1'b1;
    logic          in_ready, shift_en, lb_wr_en, win_valid, frame_done, busy;
    logic [CW-1:0] win_col;
    logic [RW-1:0] win_row;

    sobel_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .COL_W(CW), .ROW_W(RW)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .shift_en   (shift_en),
        .lb_wr_en   (lb_wr_en),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_col    (win_col),
        .win_row    (win_row),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    // Expected window centres, encoded row*16+col: (1,1)(1,2)(1,3)(2,1)(2,2)(2,3)
    int exp_win [6] = '{17, 18, 19, 33, 34, 35};

    // Observation record, filled on every falling edge
    int cyc = 0;
    int n_shift = 0;
    int n_lbmis = 0;
    int first_wv = -1;
    int win_q[$];
    int acc_cyc[$];
    int done_cyc[$];

    always @(negedge clock) begin
        cyc++;
        if (lb_wr_en !== shift_en) n_lbmis++;
        if (shift_en) begin
            n_shift++;
            acc_cyc.push_back(cyc);
        end
        if (win_valid && first_wv < 0) first_wv = cyc;
        if (win_valid && win_ready) win_q.push_back(int'(win_row) * 16 + int'(win_col));
        if (frame_done) done_cyc.push_back(cyc);
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_obs();
        n_shift  = 0;
        first_wv = -1;
        win_q.delete();
        acc_cyc.delete();
        done_cyc.delete();
    endtask

    // Offer pixels until n accepts are counted; optionally stall the first window for 3 cycles
    task automatic send(input int n, input bit stall_first);
        int  t = 0;
        bit  stalled = 1'b0;
        in_valid = 1'b1;
        while (n_shift < n && t < 300) begin
            if (stall_first && !stalled && win_valid) begin
                win_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clock);
                    check_eq("stall_in_ready", int'(in_ready), 0);
                    check_eq("stall_shift_en", int'(shift_en), 0);
                    check_eq("stall_win_col", int'(win_col), 1);
                    check_eq("stall_win_row", int'(win_row), 1);
                    @(posedge clock); #1;
                end
                win_ready = 1'b1;
                stalled   = 1'b1;
            end
            @(posedge clock); #1;
            t++;
        end
        in_valid = 1'b0;
        check_eq("send_count", n_shift, n);
    endtask

    task automatic wait_done(input int k);
        int t = 0;
        while (done_cyc.size() < k && t < 100) begin
            @(posedge clock); #1;
            t++;
        end
        check_eq("frame_done_seen", done_cyc.size(), k);
    endtask

    task automatic check_wins(input int frames);
        check_eq("win_count", win_q.size(), 6 * frames);
        for (int i = 0; i < 6 * frames; i++) begin
            if (i < win_q.size()) check_eq("win_coord", win_q[i], exp_win[i % 6]);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_win_valid", int'(win_valid), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_frame_done", int'(frame_done), 0);
        check_eq("rst_win_col", int'(win_col), 0);
        check_eq("rst_win_row", int'(win_row), 0);
        reset = 1'b0;
        @(posedge clock); #1;
        check_eq("idle_in_ready", int'(in_ready), 1);

        // Continuous 20-pixel frame
        clear_obs();
        send(20, 1'b0);
        wait_done(1);
        @(negedge clock);
        check_eq("post_done_busy", int'(busy), 0);
        repeat (3) @(posedge clock);
        #1;
        check_eq("frame_done_pulses", done_cyc.size(), 1);
        if (acc_cyc.size() >= 20 && done_cyc.size() >= 1)
            check_eq("done_latency", done_cyc[0] - acc_cyc[19], 2);
        check_wins(1);

        // Output stall at the first window
        clear_obs();
        send(20, 1'b1);
        wait_done(1);
        check_wins(1);
        repeat (2) @(posedge clock);
        #1;

        // Input gap after the first two rows
        clear_obs();
        send(10, 1'b0);
        repeat (5) @(negedge clock);
        check_eq("gap_win_valid", int'(win_valid), 0);
        check_eq("gap_busy", int'(busy), 1);
        check_eq("gap_in_ready", int'(in_ready), 1);
        check_eq("gap_no_windows", win_q.size(), 0);
        @(posedge clock); #1;
        send(20, 1'b0);
        wait_done(1);
        if (acc_cyc.size() >= 13)
            check_eq("first_win_latency", first_wv - acc_cyc[12], 1);
        check_wins(1);
        repeat (2) @(posedge clock);
        #1;

        // Reset in the middle of RUN
        clear_obs();
        send(13, 1'b0);
        check_eq("pre_rst_win_valid", int'(win_valid), 1);
        reset = 1'b1;
        @(posedge clock); #1;
        check_eq("mid_rst_win_valid", int'(win_valid), 0);
        check_eq("mid_rst_busy", int'(busy), 0);
        check_eq("mid_rst_win_col", int'(win_col), 0);
        check_eq("mid_rst_win_row", int'(win_row), 0);
        reset = 1'b0;
        @(posedge clock); #1;
        clear_obs();
        send(20, 1'b0);
        wait_done(1);
        check_wins(1);
        repeat (2) @(posedge clock);
        #1;

        // Two frames back to back
        clear_obs();
        send(40, 1'b0);
        wait_done(2);
        check_wins(2);
        if (acc_cyc.size() >= 21 && done_cyc.size() >= 1)
            check_eq("b2b_after_done", int'(acc_cyc[20] >= done_cyc[0]), 1);
        check_eq("lb_wr_en_eq_shift_en", n_lbmis, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
